// File: rtl/ksk_mem_pp.sv
// ksk_mem_pp: multi-bank key-switching-key buffer. The AXI loader streams beats into
// the fill bank while the vector processor reads full rows from the read bank.
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   i_axi_wr_en/addr/wr_data         AXI beat write (beat index within the fill bank)
//   o_axi_wr_ready, o_axi_wr_err     fill bank not full; pulse on out-of-range beat
//   i_fill_done                      commit the fill bank
//   i_vp_rd_en/rd_addr               VP row read request
//   o_vp_rd_data/rd_valid            row data, valid NB_PIPE+1 cycles after request
//   o_rd_bank_ready, i_vp_rd_release read bank full; free the read bank
//   o_full_cnt                       number of full banks
module ksk_mem_pp #(
    parameter int DATA_WIDTH     = 64,
    parameter int NUM_LANE       = 128,
    parameter int NB_PIPE        = 1,
    parameter int KSK_MEM_DEPTH  = 9216,
    parameter int NUM_BANK       = 2,
    parameter int AXI_DATA_WIDTH = 512,
    parameter int AXI_ADDR_WIDTH = 64,
    localparam int KAW = $clog2(KSK_MEM_DEPTH),
    localparam int ROW_W = NUM_LANE * DATA_WIDTH,
    localparam int CW = $clog2(NUM_BANK + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      i_axi_wr_en,
    input  logic [AXI_ADDR_WIDTH-1:0] i_axi_addr,
    input  logic [AXI_DATA_WIDTH-1:0] i_axi_wr_data,
    output logic                      o_axi_wr_ready,
    output logic                      o_axi_wr_err,
    input  logic                      i_fill_done,
    input  logic                      i_vp_rd_en,
    input  logic [KAW-1:0]            i_vp_rd_addr,
    output logic [ROW_W-1:0]          o_vp_rd_data,
    output logic                      o_vp_rd_valid,
    output logic                      o_rd_bank_ready,
    input  logic                      i_vp_rd_release,
    output logic [CW-1:0]             o_full_cnt
);

    localparam int BEATS = ROW_W / AXI_DATA_WIDTH;
    localparam int LB    = $clog2(BEATS);
    localparam int SW    = (LB > 0) ? LB : 1;
    localparam int SELW  = (NUM_BANK > 1) ? $clog2(NUM_BANK) : 1;
    localparam int MAW   = (NUM_BANK * KSK_MEM_DEPTH > 1) ?
                           $clog2(NUM_BANK * KSK_MEM_DEPTH) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] W_LIM =
        AXI_ADDR_WIDTH'(KSK_MEM_DEPTH * BEATS);
    localparam logic [KAW:0] R_LIM = (KAW+1)'(KSK_MEM_DEPTH);

    function automatic logic [SELW-1:0] f_next(input logic [SELW-1:0] s);
        return (int'(s) == NUM_BANK - 1) ? '0 : s + 1'b1;
    endfunction

    logic [NUM_BANK-1:0] r_full;
    logic [NUM_BANK-1:0] w_full_nxt;
    logic [SELW-1:0]     r_wr_sel;
    logic [SELW-1:0]     r_rd_sel;
    logic                r_err;
    logic [CW-1:0]       w_cnt;

    logic                w_wr_ready;
    logic                w_wr_inrange;
    logic                w_wr_acc;
    logic                w_commit;
    logic                w_release;
    logic                w_rd_acc;
    logic [KAW-1:0]      w_row;
    logic [SW-1:0]       w_slot;
    logic [MAW-1:0]      w_widx;
    logic [MAW-1:0]      w_ridx;

    assign w_wr_ready   = !r_full[r_wr_sel];
    assign w_wr_inrange = (i_axi_addr < W_LIM);
    assign w_wr_acc     = i_axi_wr_en && w_wr_ready && w_wr_inrange;
    assign w_commit     = i_fill_done && !r_full[r_wr_sel];
    assign w_release    = i_vp_rd_release && r_full[r_rd_sel];
    assign w_rd_acc     = i_vp_rd_en && r_full[r_rd_sel] &&
                          ({1'b0, i_vp_rd_addr} < R_LIM);

    // Beat a maps to row a/BEATS, slot a%BEATS (BEATS is a power of two).
    assign w_row  = i_axi_addr[LB +: KAW];
    assign w_slot = (BEATS > 1) ? i_axi_addr[SW-1:0] : '0;
    assign w_widx = MAW'(int'(r_wr_sel) * KSK_MEM_DEPTH + int'(w_row));
    assign w_ridx = MAW'(int'(r_rd_sel) * KSK_MEM_DEPTH + int'(i_vp_rd_addr));

    // Commit sets the fill bank, release clears the read bank; they can
    // never target the same bank, so both apply independently.
    always_comb begin
        w_full_nxt = r_full;
        if (w_commit)
            w_full_nxt[r_wr_sel] = 1'b1;
        if (w_release)
            w_full_nxt[r_rd_sel] = 1'b0;
    end

    always_comb begin
        w_cnt = '0;
        for (int i = 0; i < NUM_BANK; i++)
            w_cnt = w_cnt + CW'(r_full[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_full   <= '0;
            r_wr_sel <= '0;
            r_rd_sel <= '0;
            r_err    <= 1'b0;
        end else begin
            r_full <= w_full_nxt;
            r_err  <= i_axi_wr_en && w_wr_ready && !w_wr_inrange;
            if (w_commit)
                r_wr_sel <= f_next(r_wr_sel);
            if (w_release)
                r_rd_sel <= f_next(r_rd_sel);
        end
    end

    // One RAM per slot so a full row is read in a single cycle while
    // the AXI side writes one slot per beat.
    logic [ROW_W-1:0] w_ram_row;

    for (genvar s = 0; s < BEATS; s++) begin : g_slot
        logic [AXI_DATA_WIDTH-1:0] r_mem [NUM_BANK*KSK_MEM_DEPTH];
        logic [AXI_DATA_WIDTH-1:0] r_q;

        always_ff @(posedge clk) begin
            if (w_wr_acc && (w_slot == SW'(s)))
                r_mem[w_widx] <= i_axi_wr_data;
        end

        // Loads only on an accepted read so the output holds between reads.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_q <= '0;
            else if (w_rd_acc)
                r_q <= r_mem[w_ridx];
        end

        assign w_ram_row[s*AXI_DATA_WIDTH +: AXI_DATA_WIDTH] = r_q;
    end

    logic [ROW_W-1:0] w_sd [NB_PIPE+1];
    logic [NB_PIPE:0] r_pv;

    assign w_sd[0] = w_ram_row;

    for (genvar p = 1; p <= NB_PIPE; p++) begin : g_pipe
        logic [ROW_W-1:0] r_d;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                r_d <= '0;
            else if (r_pv[p-1])
                r_d <= w_sd[p-1];
        end

        assign w_sd[p] = r_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pv <= '0;
        end else begin
            r_pv[0] <= w_rd_acc;
            for (int i = 1; i <= NB_PIPE; i++)
                r_pv[i] <= r_pv[i-1];
        end
    end

    assign o_axi_wr_ready  = w_wr_ready;
    assign o_axi_wr_err    = r_err;
    assign o_rd_bank_ready = r_full[r_rd_sel];
    assign o_full_cnt      = w_cnt;
    assign o_vp_rd_data    = w_sd[NB_PIPE];
    assign o_vp_rd_valid   = r_pv[NB_PIPE];

endmodule

// File: tb/tb_ksk_mem_pp.sv
// tb_ksk_mem_pp: directed bench for ksk_mem_pp with a bank/RAM model and a
// scoreboard queue of expected read rows with their due cycle.
module tb_ksk_mem_pp;

    localparam int DW    = 16;
    localparam int NL    = 8;
    localparam int NP    = 1;
    localparam int DEPTH = 6;
    localparam int NB    = 2;
    localparam int AXW   = 32;
    localparam int AAW   = 32;
    localparam int BEATS = NL * DW / AXW;
    localparam int LIM   = DEPTH * BEATS;
    localparam int KAW   = $clog2(DEPTH);
    localparam int ROW_W = NL * DW;
    localparam int CW    = $clog2(NB + 1);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             i_axi_wr_en = 1'b0;
    logic [AAW-1:0]   i_axi_addr = '0;
    logic [AXW-1:0]   i_axi_wr_data = '0;
    logic             o_axi_wr_ready;
    logic             o_axi_wr_err;
    logic             i_fill_done = 1'b0;
    logic             i_vp_rd_en = 1'b0;
    logic [KAW-1:0]   i_vp_rd_addr = '0;
    logic [ROW_W-1:0] o_vp_rd_data;
    logic             o_vp_rd_valid;
    logic             o_rd_bank_ready;
    logic             i_vp_rd_release = 1'b0;
    logic [CW-1:0]    o_full_cnt;

    ksk_mem_pp #(
        .DATA_WIDTH(DW), .NUM_LANE(NL), .NB_PIPE(NP),
        .KSK_MEM_DEPTH(DEPTH), .NUM_BANK(NB),
        .AXI_DATA_WIDTH(AXW), .AXI_ADDR_WIDTH(AAW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .i_axi_wr_en(i_axi_wr_en), .i_axi_addr(i_axi_addr),
        .i_axi_wr_data(i_axi_wr_data), .o_axi_wr_ready(o_axi_wr_ready),
        .o_axi_wr_err(o_axi_wr_err), .i_fill_done(i_fill_done),
        .i_vp_rd_en(i_vp_rd_en), .i_vp_rd_addr(i_vp_rd_addr),
        .o_vp_rd_data(o_vp_rd_data), .o_vp_rd_valid(o_vp_rd_valid),
        .o_rd_bank_ready(o_rd_bank_ready),
        .i_vp_rd_release(i_vp_rd_release), .o_full_cnt(o_full_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [ROW_W-1:0] d;
        int               due;
    } exp_t;

    exp_t             q[$];
    int               checks = 0;
    int               failures = 0;
    logic [AXW-1:0]   mm [NB][LIM];
    bit               m_full [NB];
    int               m_wr = 0;
    int               m_rd = 0;
    logic [ROW_W-1:0] m_last = '0;

    task automatic chk(input string tag, input logic [ROW_W-1:0] obs,
                       input logic [ROW_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ROW_W-1:0] row(input int b, input int r);
        logic [ROW_W-1:0] v;
        for (int s = 0; s < BEATS; s++)
            v[s*AXW +: AXW] = mm[b][r*BEATS + s];
        return v;
    endfunction

    function automatic int mcnt();
        int n = 0;
        for (int i = 0; i < NB; i++)
            n += int'(m_full[i]);
        return n;
    endfunction

    // Apply the currently driven inputs for one clock edge, update the
    // model, then check the control outputs.
    task automatic tick();
        bit   wrdy;
        bit   c;
        bit   r;
        logic e_err;
        wrdy  = !m_full[m_wr];
        e_err = i_axi_wr_en && wrdy && (int'(i_axi_addr) >= LIM);
        if (i_vp_rd_en && m_full[m_rd] && int'(i_vp_rd_addr) < DEPTH)
            q.push_back('{row(m_rd, int'(i_vp_rd_addr)), cyc + 1 + NP});
        if (i_axi_wr_en && wrdy && int'(i_axi_addr) < LIM)
            mm[m_wr][int'(i_axi_addr)] = i_axi_wr_data;
        c = i_fill_done && !m_full[m_wr];
        r = i_vp_rd_release && m_full[m_rd];
        if (c) begin
            m_full[m_wr] = 1'b1;
            m_wr = (m_wr + 1) % NB;
        end
        if (r) begin
            m_full[m_rd] = 1'b0;
            m_rd = (m_rd + 1) % NB;
        end
        @(posedge clk);
        #1;
        i_axi_wr_en     = 1'b0;
        i_fill_done     = 1'b0;
        i_vp_rd_en      = 1'b0;
        i_vp_rd_release = 1'b0;
        chk("wr_ready", o_axi_wr_ready, !m_full[m_wr]);
        chk("bank_ready", o_rd_bank_ready, m_full[m_rd]);
        chk("full_cnt", o_full_cnt, mcnt());
        chk("wr_err", o_axi_wr_err, e_err);
        if (!o_vp_rd_valid)
            chk("rd_hold", o_vp_rd_data, m_last);
    endtask

    task automatic wr(input int a, input logic [AXW-1:0] d);
        i_axi_wr_en   = 1'b1;
        i_axi_addr    = AAW'(a);
        i_axi_wr_data = d;
    endtask

    task automatic rd(input int a);
        i_vp_rd_en   = 1'b1;
        i_vp_rd_addr = KAW'(a);
    endtask

    task automatic drain();
        repeat (NP + 3) tick();
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (o_vp_rd_valid) begin
                if (q.size() == 0) begin
                    chk("rd_spurious", o_vp_rd_valid, 1'b0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("rd_data", o_vp_rd_data, e.d);
                    chk("rd_lat", cyc, e.due);
                    m_last = e.d;
                end
            end else if (q.size() > 0 && q[0].due <= cyc) begin
                chk("rd_missing", o_vp_rd_valid, 1'b1);
                void'(q.pop_front());
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wr_ready", o_axi_wr_ready, 1'b1);
        chk("rst_bank_ready", o_rd_bank_ready, 1'b0);
        chk("rst_valid", o_vp_rd_valid, 1'b0);
        chk("rst_err", o_axi_wr_err, 1'b0);
        chk("rst_cnt", o_full_cnt, 0);
        chk("rst_data", o_vp_rd_data, 0);
        rst_n = 1'b1;

        // Fill bank0, commit, read every row back to back.
        for (int a = 0; a < LIM; a++) begin
            wr(a, $urandom);
            tick();
        end
        i_fill_done = 1'b1;
        tick();
        for (int r = 0; r < DEPTH; r++) begin
            rd(r);
            tick();
        end
        drain();

        // Fill bank1 while reading bank0, commit, blocked write, release.
        for (int a = 0; a < LIM; a++) begin
            wr(a, $urandom);
            rd(a % DEPTH);
            tick();
        end
        i_fill_done = 1'b1;
        tick();
        wr(0, 32'hdead_beef);
        tick();
        i_vp_rd_release = 1'b1;
        tick();
        // Next fill lands in bank0 (left uncommitted for now).
        for (int a = 0; a < LIM; a++) begin
            wr(a, $urandom);
            tick();
        end
        for (int r = 0; r < DEPTH; r++) begin
            rd(r);
            tick();
        end
        drain();

        // Out-of-range beats and row addresses.
        wr(LIM, 32'h1234_5678);
        tick();
        tick();
        wr(LIM + 37, 32'h0bad_0bad);
        tick();
        rd(DEPTH);
        tick();
        rd(DEPTH + 1);
        tick();
        for (int r = 0; r < DEPTH; r++) begin
            rd(r);
            tick();
        end
        drain();

        // Last beat + commit and read + release in the same cycle.
        wr(LIM - 1, 32'hcafe_f00d);
        i_fill_done     = 1'b1;
        rd(DEPTH - 1);
        i_vp_rd_release = 1'b1;
        tick();
        for (int r = DEPTH - 1; r >= 0; r--) begin
            rd(r);
            tick();
        end
        drain();

        // No readable bank: reads yield nothing, release is ignored.
        i_vp_rd_release = 1'b1;
        tick();
        rd(0);
        tick();
        i_vp_rd_release = 1'b1;
        tick();
        drain();

        // Two full banks, streaming reads, then async reset.
        for (int b = 0; b < NB; b++) begin
            for (int a = 0; a < LIM; a++) begin
                wr(a, $urandom);
                tick();
            end
            i_fill_done = 1'b1;
            tick();
        end
        for (int r = 0; r < 3; r++) begin
            rd(r);
            tick();
        end
        rd(3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", o_vp_rd_valid, 1'b0);
        chk("arst_cnt", o_full_cnt, 0);
        chk("arst_wr_ready", o_axi_wr_ready, 1'b1);
        chk("arst_bank_ready", o_rd_bank_ready, 1'b0);
        i_vp_rd_en = 1'b0;
        q.delete();
        for (int i = 0; i < NB; i++)
            m_full[i] = 1'b0;
        m_wr   = 0;
        m_rd   = 0;
        m_last = '0;
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;

        // Fresh fill and read from bank0.
        for (int a = 0; a < LIM; a++) begin
            wr(a, $urandom);
            tick();
        end
        i_fill_done = 1'b1;
        tick();
        for (int r = 0; r < DEPTH; r++) begin
            rd(r);
            tick();
        end
        drain();

        chk("sb_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
